// File: rtl/prm_sched_pkg.sv
// rtl/prm_sched_pkg.sv - shared state encoding and width helpers for the PRM edge-mask scheduler
package prm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int CODE_W_DEF = 15;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prm_popcount.sv
// rtl/prm_popcount.sv - combinational population count of one mask beat
module prm_popcount
  import prm_sched_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]        data,
  output logic [cnt_w(W)-1:0] count
);

  localparam int CW = cnt_w(W);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/prm_edge_mask_sched.sv
// rtl/prm_edge_mask_sched.sv - feeds obstacle codes to the edge-check bank, accumulates the blocked mask, streams it out
module prm_edge_mask_sched
  import prm_sched_pkg::*;
#(
  parameter int NUM_EDGES = 1024,
  parameter int CODE_W    = CODE_W_DEF,
  parameter int OUT_W     = 32,
  parameter int MAX_OBS   = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        obs_valid,
  output logic                        obs_ready,
  input  logic [CODE_W-1:0]           obs_code,
  input  logic                        obs_last,
  output logic [CODE_W-1:0]           chk_code,
  input  logic [NUM_EDGES-1:0]        chk_mask,
  output logic                        mask_valid,
  input  logic                        mask_ready,
  output logic [OUT_W-1:0]            mask_data,
  output logic                        mask_last,
  output logic                        done,
  output logic [cnt_w(NUM_EDGES)-1:0] blocked_cnt,
  output logic                        overflow,
  output logic                        busy
);

  localparam int NUM_BEATS = NUM_EDGES / OUT_W;
  localparam int BEAT_W    = idx_w(NUM_BEATS);
  localparam int CNT_W     = cnt_w(NUM_EDGES);
  localparam int POP_W     = cnt_w(OUT_W);
  localparam int OBS_W     = cnt_w(MAX_OBS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [OBS_W-1:0]  OBS_MAX   = OBS_W'(MAX_OBS);

  state_e                state_q, state_d;
  logic [NUM_EDGES-1:0]  acc_q, acc_d;
  logic [CODE_W-1:0]     chk_code_q, chk_code_d;
  logic                  pv_q, pv_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [OBS_W-1:0]      obs_cnt_q, obs_cnt_d;
  logic [CNT_W-1:0]      sum_q, sum_d;
  logic [CNT_W-1:0]      blocked_q, blocked_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [NUM_BEATS-1:0][OUT_W-1:0] acc_beats;
  logic [OUT_W-1:0]      slice;
  logic [POP_W-1:0]      slice_pop;
  logic                  obs_hs;
  logic                  beat_hs;

  // An overflowed frame reports every edge blocked; counting the forced slice yields NUM_EDGES.
  assign acc_beats = acc_q;
  assign slice     = ovf_q ? {OUT_W{1'b1}} : acc_beats[beat_q];

  prm_popcount #(.W(OUT_W)) u_popcount (
    .data  (slice),
    .count (slice_pop)
  );

  assign obs_ready   = (state_q == IDLE) || (state_q == ACCUM);
  assign obs_hs      = obs_valid && obs_ready;
  assign mask_valid  = (state_q == OUT);
  assign beat_hs     = mask_valid && mask_ready;
  assign mask_data   = slice;
  assign mask_last   = mask_valid && (beat_q == LAST_BEAT);
  assign chk_code    = chk_code_q;
  assign done        = done_q;
  assign blocked_cnt = blocked_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    chk_code_d = chk_code_q;
    pv_d       = pv_q;
    beat_d     = beat_q;
    obs_cnt_d  = obs_cnt_q;
    sum_d      = sum_q;
    blocked_d  = blocked_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        // chk_mask only matters when chk_code holds a freshly accepted code
        if (pv_q) acc_d = acc_q | chk_mask;
        pv_d = obs_hs;
        if (obs_hs) begin
          chk_code_d = obs_code;
          if (obs_cnt_q == OBS_MAX) ovf_d = 1'b1;
          else obs_cnt_d = obs_cnt_q + OBS_W'(1);
          state_d = obs_last ? DRAIN : ACCUM;
        end
      end
      DRAIN: begin
        if (pv_q) acc_d = acc_q | chk_mask;
        pv_d    = 1'b0;
        beat_d  = '0;
        sum_d   = '0;
        state_d = OUT;
      end
      OUT: begin
        if (beat_hs) begin
          sum_d  = sum_q + CNT_W'(slice_pop);
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            blocked_d = sum_q + CNT_W'(slice_pop);
            done_d    = 1'b1;
            acc_d     = '0;
            obs_cnt_d = '0;
            ovf_d     = 1'b0;
            beat_d    = '0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      chk_code_q <= '0;
      pv_q       <= 1'b0;
      beat_q     <= '0;
      obs_cnt_q  <= '0;
      sum_q      <= '0;
      blocked_q  <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      chk_code_q <= chk_code_d;
      pv_q       <= pv_d;
      beat_q     <= beat_d;
      obs_cnt_q  <= obs_cnt_d;
      sum_q      <= sum_d;
      blocked_q  <= blocked_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_sched.sv
// tb/tb_prm_edge_mask_sched.sv - scoreboard bench for prm_edge_mask_sched with a lookup-table check bank
module tb_prm_edge_mask_sched;

  localparam int NE = 64;
  localparam int OW = 16;
  localparam int MO = 4;
  localparam int CW = 15;
  localparam int NB = NE / OW;

  typedef logic [CW-1:0] code_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          obs_valid = 1'b0;
  logic          obs_ready;
  logic [CW-1:0] obs_code = '0;
  logic          obs_last = 1'b0;
  logic [CW-1:0] chk_code;
  logic [NE-1:0] chk_mask;
  logic          mask_valid;
  logic          mask_ready = 1'b1;
  logic [OW-1:0] mask_data;
  logic          mask_last;
  logic          done;
  logic [6:0]    blocked_cnt;
  logic          overflow;
  logic          busy;

  int vecs = 0;
  int errs = 0;
  logic [OW:0] beat_q[$];
  int          cnt_q[$];
  code_q_t     codes;
  logic        x_mode = 1'b0;
  logic        bench_pv = 1'b0;
  logic        done_pending = 1'b0;
  int          exp_cnt_pending = 0;
  int          done_seen = 0;

  always #5 clk = ~clk;

  prm_edge_mask_sched #(
    .NUM_EDGES (NE),
    .CODE_W    (CW),
    .OUT_W     (OW),
    .MAX_OBS   (MO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .obs_valid   (obs_valid),
    .obs_ready   (obs_ready),
    .obs_code    (obs_code),
    .obs_last    (obs_last),
    .chk_code    (chk_code),
    .chk_mask    (chk_mask),
    .mask_valid  (mask_valid),
    .mask_ready  (mask_ready),
    .mask_data   (mask_data),
    .mask_last   (mask_last),
    .done        (done),
    .blocked_cnt (blocked_cnt),
    .overflow    (overflow),
    .busy        (busy)
  );

  function automatic logic [NE-1:0] bank(input logic [CW-1:0] c);
    case (c)
      15'd1:   return 64'h0000_0000_0000_8001;
      15'd2:   return 64'h0000_0000_0000_0001;
      15'd3:   return 64'h0000_0000_0002_0000;
      15'd4:   return 64'h8000_0000_0000_0000;
      15'd5:   return 64'h0000_0000_0000_0003;
      15'd6:   return 64'h0001_0000_0000_0000;
      default: return '0;
    endcase
  endfunction

  // Garbage (partly X) on the bank response whenever the DUT has no fresh code applied.
  always_comb begin
    chk_mask = bank(chk_code);
    if (x_mode && !bench_pv) chk_mask = {32{2'bx1}};
  end

  always @(posedge clk) bench_pv <= rst_n && obs_valid && obs_ready;

  always @(negedge clk) begin
    logic [OW:0] e;
    if (!rst_n) begin
      done_pending = 1'b0;
    end else begin
      if (done_pending) begin
        done_pending = 1'b0;
        vecs++;
        if (done !== 1'b1 || int'(blocked_cnt) != exp_cnt_pending) begin
          errs++;
          $display("FAIL done_cnt: done=%b blocked_cnt=%0d, required done=1 blocked_cnt=%0d", done, blocked_cnt, exp_cnt_pending);
        end
        done_seen++;
      end else if (done !== 1'b0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_done: done=%b, required 0", done);
      end
      if (mask_valid && mask_ready) begin
        vecs++;
        if (beat_q.size() == 0) begin
          errs++;
          $display("FAIL extra_beat: data=%h last=%b, required no beat", mask_data, mask_last);
        end else begin
          e = beat_q.pop_front();
          if ({mask_last, mask_data} !== e) begin
            errs++;
            $display("FAIL beat: last=%b data=%h, required last=%b data=%h", mask_last, mask_data, e[OW], e[OW-1:0]);
          end
          if (e[OW]) begin
            done_pending = 1'b1;
            exp_cnt_pending = (cnt_q.size() != 0) ? cnt_q.pop_front() : -1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit gaps, output int stalls);
    logic [NE-1:0] m;
    bit hs;
    int w;
    m = '0;
    stalls = 0;
    foreach (codes[i]) m |= bank(codes[i]);
    if (codes.size() > MO) m = '1;
    for (int b = 0; b < NB; b++) beat_q.push_back({b == NB - 1, m[b*OW +: OW]});
    cnt_q.push_back($countones(m));
    foreach (codes[i]) begin
      obs_valid = 1'b1;
      obs_code  = codes[i];
      obs_last  = (i == codes.size() - 1);
      w = 0;
      hs = 1'b0;
      do begin
        @(negedge clk);
        hs = obs_ready;
        tick();
        if (!hs) stalls++;
        w++;
      end while (!hs && w < 50);
      if (!hs) begin
        vecs++;
        errs++;
        $display("FAIL obs_accept_timeout: obs_ready=%b, required 1", obs_ready);
      end
      if (gaps) begin
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        obs_code  = '1;
        tick();
      end
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    int w;
    start = done_seen;
    w = 0;
    while (done_seen == start && w < 300) begin
      tick();
      w++;
    end
    vecs++;
    if (done_seen == start || beat_q.size() != 0) begin
      errs++;
      $display("FAIL frame_complete: done_seen=%0d beats_left=%0d, required done and 0 beats left", done_seen - start, beat_q.size());
    end
  endtask

  task automatic wait_mask_valid();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mask_valid && w < 50);
    vecs++;
    if (!mask_valid) begin
      errs++;
      $display("FAIL mask_valid_timeout: mask_valid=%b, required 1", mask_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if ({obs_ready, mask_valid, done, busy, overflow} !== 5'b10000) begin
      errs++;
      $display("FAIL reset_flags: rdy,mv,done,busy,ovf=%b, required 10000", {obs_ready, mask_valid, done, busy, overflow});
    end
    vecs++;
    if (blocked_cnt !== 7'd0 || chk_code !== '0) begin
      errs++;
      $display("FAIL reset_regs: blocked_cnt=%0d chk_code=%h, required 0 0", blocked_cnt, chk_code);
    end
    tick();
  endtask

  task automatic test_single();
    int st;
    codes = {15'd1};
    send_frame(1'b0, st);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int st;
    codes = {15'd2, 15'd3, 15'd4};
    send_frame(1'b0, st);
    vecs++;
    if (st !== 0) begin
      errs++;
      $display("FAIL obs_ready_accum: stall_cycles=%0d, required 0", st);
    end
    wait_done();
  endtask

  task automatic test_stall();
    int st;
    codes = {15'd2, 15'd3, 15'd4};
    mask_ready = 1'b0;
    send_frame(1'b0, st);
    wait_mask_valid();
    tick();
    mask_ready = 1'b1;
    tick();
    mask_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vecs++;
      if (mask_valid !== 1'b1 || mask_data !== 16'h0002 || mask_last !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold: mv=%b data=%h last=%b, required 1 0002 0", mask_valid, mask_data, mask_last);
      end
    end
    tick();
    mask_ready = 1'b1;
    wait_done();
  endtask

  task automatic test_overflow();
    int st;
    codes = {15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6};
    send_frame(1'b0, st);
    @(negedge clk);
    vecs++;
    if (overflow !== 1'b1) begin
      errs++;
      $display("FAIL overflow_set: overflow=%b, required 1", overflow);
    end
    tick();
    wait_done();
    codes = {15'd2};
    send_frame(1'b0, st);
    @(negedge clk);
    vecs++;
    if (overflow !== 1'b0) begin
      errs++;
      $display("FAIL overflow_clear: overflow=%b, required 0", overflow);
    end
    tick();
    wait_done();
    codes = {15'd1, 15'd2, 15'd3, 15'd4};
    send_frame(1'b0, st);
    @(negedge clk);
    vecs++;
    if (overflow !== 1'b0) begin
      errs++;
      $display("FAIL overflow_at_max: overflow=%b, required 0", overflow);
    end
    tick();
    wait_done();
  endtask

  task automatic test_reset_mid_out();
    int st;
    codes = {15'd1};
    send_frame(1'b0, st);
    wait_mask_valid();
    tick();
    tick();
    rst_n = 1'b0;
    mask_ready = 1'b0;
    beat_q.delete();
    cnt_q.delete();
    tick();
    rst_n = 1'b1;
    mask_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (mask_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_out: mv=%b busy=%b done=%b ovf=%b, required 0 0 0 0", mask_valid, busy, done, overflow);
    end
    repeat (3) tick();
    codes = {15'd0};
    send_frame(1'b0, st);
    wait_done();
  endtask

  task automatic test_gapped();
    int st;
    x_mode = 1'b1;
    codes = {15'd2, 15'd3, 15'd4};
    send_frame(1'b1, st);
    wait_done();
    x_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid_out();
    test_gapped();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/prm_edge_mask_sched.md
Name: prm_edge_mask_sched

Overview:
- Sequences one roadmap-update frame through the bank of combinational obstacle-check cells (one cell per PRM edge, 15-bit code in, edge_mask bit out).
- Accepts a stream of 15-bit obstacle codes and drives each code to the bank.
- ORs the bank's NUM_EDGES-bit response into a sticky blocked-edge accumulator.
- After the frame's last code, streams the accumulated mask to the graph-search stage in OUT_W-bit beats, then reports the blocked-edge count.

Parameters:
- NUM_EDGES, 1024, number of edge-check cells in the bank; must be a multiple of OUT_W.
- CODE_W, 15, obstacle code width; matches the check-cell inputs A..O, where bit 0 = A and bit 14 = O.
- OUT_W, 32, mask output beat width.
- MAX_OBS, 4096, obstacle codes per frame before overflow.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- obs_valid  in  1  obstacle code valid
- obs_ready  out  1  scheduler can accept a code
- obs_code  in  CODE_W  obstacle code
- obs_last  in  1  final code of the frame
- chk_code  out  CODE_W  registered code driven to the check bank
- chk_mask  in  NUM_EDGES  bank response to chk_code (combinational, same cycle)
- mask_valid  out  1  output beat valid
- mask_ready  in  1  downstream accepts the beat
- mask_data  out  OUT_W  edge bits [beat*OUT_W +: OUT_W]
- mask_last  out  1  final beat of the frame
- done  out  1  one-cycle pulse after the last beat is accepted
- blocked_cnt  out  clog2(NUM_EDGES+1)  number of blocked edges; valid while done=1, held until the next frame's done
- overflow  out  1  sticky per frame; frame exceeded MAX_OBS
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low, on rst_n.
- Reset values: state=IDLE; acc, chk_code, beat index, obs_cnt, blocked_cnt all 0; overflow=0; all valid/pulse outputs 0.
- Reset asserted mid-frame discards the frame. No mask is emitted and done does not pulse.
- States:
  - IDLE: obs_ready=1. An obs handshake registers the code into chk_code and goes to ACCUM. If obs_last is set on that code, go to DRAIN instead.
  - ACCUM: obs_ready=1. Every cycle, acc <= acc | chk_mask when the pipe-valid flag is set. An obs handshake loads chk_code and sets pipe-valid; a cycle with no handshake clears pipe-valid. A handshake with obs_last goes to DRAIN.
  - DRAIN: obs_ready=0. Performs the final OR of the last code's response, clears pipe-valid, then goes to OUT with beat=0.
  - OUT: mask_valid=1 and mask_data=acc slice[beat]. mask_last=1 when beat==NUM_EDGES/OUT_W-1. On mask_ready: add popcount(slice) to the running count and increment beat. Handshake on the last beat: blocked_cnt <= final sum, pulse done, clear acc, obs_cnt and overflow, go to IDLE.
- Latency:
  - A code accepted in cycle t is applied to the bank at t+1 and OR'd into acc at the end of t+1.
  - The first beat is presented 2 cycles after the obs_last handshake.
- Back-to-back codes: one code per cycle is sustained, with no bubbles.
- Frame length: a single-code frame (obs_last on the first code) is legal.
- Overflow:
  - obs_cnt counts accepted codes and saturates at MAX_OBS.
  - A handshake while obs_cnt==MAX_OBS sets overflow. The code is still applied.
  - If overflow is set at OUT, every beat is forced to all-ones and blocked_cnt=NUM_EDGES. This is the conservative choice: every edge is treated as blocked.
- Output stall: mask_data and mask_last hold stable while mask_valid=1 and mask_ready=0.
- Simultaneous events: obs_valid during DRAIN/OUT is not accepted (obs_ready=0) and must be held by the source.
- Ungated inputs: chk_mask is ignored whenever pipe-valid=0. X on chk_mask in that case must not propagate.

Decomposition:
- Shared package prm_sched_pkg:
  - state enum (IDLE, ACCUM, DRAIN, OUT)
  - CODE_W default
  - count-width functions (clog2-based)
- Sub-module prm_popcount (param W, combinational popcount of one OUT_W slice), instantiated once in the OUT path.
- The check bank itself is instantiated outside this block.

Test Plan (NUM_EDGES=64, OUT_W=16, MAX_OBS=4; bench models the bank with a lookup table):
- Single code 0x0001 with obs_last, bank returns 0x0000_0000_0000_8001:
  - beats 0x8001, 0, 0, 0 in that order
  - mask_last on beat 3
  - blocked_cnt=2, done pulses once
- Three back-to-back codes returning bits 0, 17 and 63:
  - beats 0x0001, 0x0002, 0x0000, 0x8000
  - blocked_cnt=3
  - obs_ready stays high through ACCUM
- mask_ready held low for 5 cycles on beat 1: data stable, no beat skipped or duplicated, blocked_cnt unchanged.
- Six codes (exceeds MAX_OBS=4): overflow=1, all beats 0xFFFF, blocked_cnt=64; the next frame starts with overflow=0.
- rst_n low for 1 cycle during OUT beat 2:
  - state IDLE, mask_valid=0, no done
  - a following frame with bank response 0 yields blocked_cnt=0
- Gapped input (obs_valid toggling) with X driven on chk_mask during gap cycles: acc is unaffected and the result equals the gap-free run.
